// File: rtl/data_responder.sv
// data_responder: wait-stated word RAM responder for the core data port; optional DATA_RESPONDER_BOUNDS_CHECK_EN flags and suppresses out-of-range accesses
module data_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int ADDR_BITS       = 10,
  parameter int LATENCY         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_req,
  input  logic                       data_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       data_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_we;
  logic [BYTE_DATA_WIDTH-1:0] r_be;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [ADDR_BITS-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic w_idle, w_go, w_we, w_blk, w_unused;
  logic [BYTE_DATA_WIDTH-1:0] w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_BITS-1:0] w_idx;
  assign w_idle     = r_state == IDLE;
  assign w_we       = w_idle ? data_we : r_we;
  assign w_be       = w_idle ? byte_enable : r_be;
  assign w_wdata    = w_idle ? wdata : r_wdata;
  assign w_idx      = w_idle ? data_addr[ADDR_BITS+1:2] : r_idx;
  assign data_valid = r_state == RESP;
  assign rdata      = r_rdata;
`ifdef DATA_RESPONDER_BOUNDS_CHECK_EN
  logic r_oor;
  // capture whether the request falls outside the RAM alongside the other fields
  always_ff @(posedge clk)
    if (!rst) r_oor <= 1'b0;
    else if (w_idle && data_req) r_oor <= |data_addr[DATA_WIDTH-1:ADDR_BITS+2];
  assign w_blk    = w_idle ? |data_addr[DATA_WIDTH-1:ADDR_BITS+2] : r_oor;
  assign data_err = data_valid & r_oor;
  assign w_unused = ^data_addr[1:0];
`else
  assign w_blk    = 1'b0;
  assign data_err = 1'b0;
  assign w_unused = ^{data_addr[DATA_WIDTH-1:ADDR_BITS+2], data_addr[1:0]};
`endif
  // next state; w_go marks the edge that enters RESP, where the RAM is accessed
  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    case (r_state)
      IDLE: begin
        w_go = data_req && (LAT == 4'd0);
        if (data_req) w_next = w_go ? RESP : WAIT;
      end
      WAIT: begin
        w_go = r_cnt == 4'd1;
        if (w_go) w_next = RESP;
      end
      default: w_next = IDLE;
    endcase
  end
  // state, wait counter and request fields latched on acceptance
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && data_req) begin
        r_cnt   <= LAT;
        r_we    <= data_we;
        r_be    <= byte_enable;
        r_wdata <= wdata;
        r_idx   <= data_addr[ADDR_BITS+1:2];
      end else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
    end
  // load data register, updated only by load responses
  always_ff @(posedge clk)
    if (!rst) r_rdata <= '0;
    else if (w_go && !w_we) r_rdata <= w_blk ? '0 : r_mem[w_idx];
  // byte-lane store into the RAM; contents survive reset
  always_ff @(posedge clk)
    if (rst && w_go && w_we && !w_blk)
      for (int i = 0; i < BYTE_DATA_WIDTH; i++)
        if (w_be[i]) r_mem[w_idx][8*i+:8] <= w_wdata[8*i+:8];
endmodule

// File: tb/tb_data_responder.sv
// tb_data_responder: randomized bench for data_responder against a transaction-level memory model
module tb_data_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst;
  logic data_req, data_we, data_valid, data_err;
  logic [3:0] byte_enable;
  logic [31:0] data_addr, wdata, rdata;
  logic b_req, b_we, b_valid, b_err;
  logic [3:0] b_be;
  logic [31:0] b_addr, b_wd, b_rdata;
  int cyc = 0, checks = 0, errors = 0, p_resp = 0;
  bit chk_on = 0, pend = 0, p_load = 0, p_err = 0, ev;
  logic [31:0] p_data = 0, exp_rdata = 0;
  logic [31:0] mem_m [1024];
  logic v, e, e1;

  data_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .ADDR_BITS(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .data_req(data_req), .data_we(data_we), .byte_enable(byte_enable),
    .data_addr(data_addr), .wdata(wdata), .data_valid(data_valid), .rdata(rdata), .data_err(data_err));

  data_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .ADDR_BITS(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_req(b_req), .data_we(b_we), .byte_enable(b_be),
    .data_addr(b_addr), .wdata(b_wd), .data_valid(b_valid), .rdata(b_rdata), .data_err(b_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // one request: model the outcome, hold req until the response, scramble fields while busy
  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output logic got_v, output logic got_e);
    int unsigned idx;
    logic blk;
    idx = 32'(addr[11:2]);
    blk = 1'b0;
`ifdef DATA_RESPONDER_BOUNDS_CHECK_EN
    blk = |addr[31:12];
`endif
    data_req = 1'b1; data_we = we; byte_enable = be; data_addr = addr; wdata = wd;
    p_load = !we;
    p_err = blk;
    p_data = (!we && !blk) ? mem_m[idx] : 32'h0;
    if (we && !blk)
      for (int l = 0; l < 4; l++) if (be[l]) mem_m[idx][8*l+:8] = wd[8*l+:8];
    p_resp = cyc + 1 + LAT;
    pend = 1'b1;
    got_v = 1'b0;
    got_e = 1'b0;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(posedge clk); #1;
      if (i == LAT) begin got_v = data_valid; got_e = data_err; end
      if (i <= LAT) begin
        data_we = 1'($urandom); byte_enable = 4'($urandom);
        data_addr = $urandom; wdata = $urandom;
      end
    end
    data_req = 1'b0; data_we = 1'b0; byte_enable = 4'h0; data_addr = 32'h0; wdata = 32'h0;
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk)
    if (chk_on) begin
      ev = pend && (cyc == p_resp);
      if (ev && p_load) exp_rdata = p_data;
      check("valid", 32'(data_valid), 32'(ev));
      check("rdata", rdata, exp_rdata);
      check("err", 32'(data_err), 32'(ev && p_err));
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; data_req = 1'b1; data_we = 1'b0; byte_enable = 4'h0; data_addr = 32'h0; wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 32'h0; b_wd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; data_req = 1'b0; chk_on = 1'b1;
    b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 32'h8; b_wd = 32'hCAFEF00D;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("lat0_valid", 32'(b_valid), 32'(j % 2));
      if (j == 1) check("lat0_err", 32'(b_err), 32'h0);
      if (j == 3) check("lat0_rdata", b_rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
      if (j == 1) begin b_we = 1'b0; b_wd = 32'h0; b_be = 4'h2; end
    end
    b_req = 1'b0;
    @(negedge clk);
    check("lat0_idle", 32'(b_valid), 32'h0);
    @(posedge clk); #1;
    do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, v, e);
    check("st_valid_t3", 32'(v), 32'h1);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, v, e);
    check("ld_deadbeef", rdata, 32'hDEADBEEF);
    do_req(1'b1, 4'hF, 32'h20, 32'h11223344, v, e);
    do_req(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, v, e);
    do_req(1'b0, 4'b0010, 32'h23, 32'h0, v, e);
    check("ld_merge", rdata, 32'h11BB33DD);
    do_req(1'b1, 4'hF, 32'h40, 32'h5, v, e);
    do_req(1'b0, 4'hF, 32'h40, 32'h0, v, e);
    data_req = 1'b1; data_we = 1'b1; byte_enable = 4'hF; data_addr = 32'h40; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; data_req = 1'b0; data_we = 1'b0; pend = 1'b0; exp_rdata = 32'h0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    do_req(1'b0, 4'hF, 32'h40, 32'h0, v, e);
    check("ld_after_rst", rdata, 32'h5);
    do_req(1'b1, 4'hF, 32'h0, 32'h12345678, v, e);
    do_req(1'b1, 4'hF, 32'h1000, 32'h1, v, e1);
    do_req(1'b0, 4'hF, 32'h0, 32'h0, v, e);
`ifdef DATA_RESPONDER_BOUNDS_CHECK_EN
    check("oor_st_err", 32'(e1), 32'h1);
    check("oor_word0", rdata, 32'h12345678);
    do_req(1'b0, 4'hF, 32'h1000, 32'h0, v, e);
    check("oor_ld_err", 32'(e), 32'h1);
    check("oor_ld_rdata", rdata, 32'h0);
`else
    check("alias_err", 32'(e1), 32'h0);
    check("alias_word0", rdata, 32'h1);
`endif
    for (int k = 0; k < 16; k++) do_req(1'b1, 4'hF, 32'(k * 4), $urandom, v, e);
    for (int n = 0; n < 300; n++) begin
      logic [19:0] up;
      up = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(1, 20'hFFFFF)) : 20'h0;
      do_req(1'($urandom), 4'($urandom), {up, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)}, $urandom, v, e);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_responder.md
# data_responder

Memory-side responder for the core's data cache interface. It accepts single load/store requests from the core LSU, inserts a fixed number of wait states, performs a word access on an internal synchronous RAM with per-byte write enables, and returns a one-cycle `data_valid` pulse. It sits outside `core`, wired port-for-port to `data_req`/`data_valid`/`data_we`/`byte_enable`/`data_addr`/`rdata`/`wdata`, and serves as the data memory model for simulation and small FPGA builds.

## Interface
- `DATA_WIDTH`, 32: data word width.
- `BYTE_DATA_WIDTH`, 4: byte lanes, = `DATA_WIDTH/8`.
- `ADDR_BITS`, 10: word-address bits; the RAM holds 2^ADDR_BITS words.
- `LATENCY`, 2: wait-state cycles between acceptance and response; range 0..15.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `data_req` input 1: request from the core; held with all request fields until `data_valid`.
- `data_we` input 1: 1 = store, 0 = load.
- `byte_enable` input BYTE_DATA_WIDTH: store byte-lane enables; ignored for loads.
- `data_addr` input DATA_WIDTH: byte address.
- `wdata` input DATA_WIDTH: store data, lane i = `wdata[8i+7:8i]`.
- `data_valid` output 1: one-cycle response pulse.
- `rdata` output DATA_WIDTH: load data, registered.
- `data_err` output 1: out-of-range flag, coincident with `data_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `data_req`=1, latch `data_we`, `byte_enable`, `wdata`, word index `data_addr[ADDR_BITS+1:2]`, range bit (`data_addr[DATA_WIDTH-1:ADDR_BITS+2]` != 0); load wait counter with `LATENCY`; go to WAIT if `LATENCY`>0, else RESP.
- WAIT: decrement counter; at counter = 1, go to RESP.
- RESP: `data_valid`=1 for this cycle; go to IDLE unconditionally.
- Memory access happens on the clock edge entering RESP: loads register the full word into `rdata`; stores write each lane with `byte_enable[i]`=1, other lanes unchanged.
- Loads return the full word irrespective of `byte_enable`; lane selection/extension is the LSU's job.
- `data_addr[1:0]` is ignored (word access).
- Stores leave `rdata` unchanged.
- Request fields are sampled only in IDLE; changes during WAIT/RESP have no effect.
- `data_req` seen in IDLE on the cycle after RESP is a new request; the core must drop `data_req` in the cycle following `data_valid`.

## Timing
- Acceptance cycle T (IDLE, `data_req`=1); `data_valid` high in cycle T+1+LATENCY, exactly one cycle.
- Load data visible on `rdata` in the `data_valid` cycle; holds until next load response.
- Store effect visible to a load accepted at or after T+2+LATENCY.
- Minimum request spacing: LATENCY+2 cycles.
- Reset (`rst`=0 at a rising edge): state IDLE, counter 0, `data_valid`=0, `rdata`=0, `data_err`=0, latched fields cleared. RAM contents are not reset. Reset mid-WAIT aborts the request: no response, no write.
- `rst` dominates `data_req` in the same cycle.

## Configuration
- `DATA_RESPONDER_BOUNDS_CHECK_EN` defined: an out-of-range request still completes with normal timing, but a store writes nothing, a load returns `rdata`=0, and `data_err`=1 in the `data_valid` cycle.
- Not defined: upper address bits are ignored (aliasing onto the RAM), and `data_err` is tied to 0.

## Test plan
- Reset, then store `wdata`=0xDEADBEEF, `byte_enable`=4'b1111, `data_addr`=0x10 at T → `data_valid` only at T+3 (LATENCY=2). A load from 0x10 then returns `rdata`=0xDEADBEEF.
- Word 0x20 holds 0x11223344. Store 0xAABBCCDD with `byte_enable`=4'b0101 → a load from 0x20 returns 0x11BB33DD.
- LATENCY=0: load accepted at T → `data_valid` at T+1. Holding `data_req` continuously produces responses at T+1, T+3, T+5, with no pulse in between.
- Assert `rst`=0 during WAIT of a store to 0x40 (old value 0x5) → no `data_valid`, all outputs are 0. A later load from 0x40 returns 0x5.
- With the macro defined: store 0x1 to `data_addr`=0x0000_1000 (ADDR_BITS=10) → `data_valid`=1 with `data_err`=1, and word 0 is unchanged. A load from the same address returns 0 with `data_err`=1.
- Without the macro: the same store writes word 0 (aliasing), and `data_err` stays 0.
